// File: rtl/plab5_mcore_acc_pkg.sv
// Shared types and constants for the memory-request access controller.
// FSM encoding, deny-response constants, default secure window and message helpers.
package plab5_mcore_acc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFwd  = 2'd1,
        StDeny = 2'd2
    } acc_state_e;

    localparam int unsigned MemTypeNbits = 3;
    localparam logic [MemTypeNbits-1:0] MemTypeRead = 3'd0;
    localparam int unsigned DenyLen = 0;

    localparam logic [31:0] SecBaseDefault  = 32'h0000_8000;
    localparam logic [31:0] SecBoundDefault = 32'h0000_FFFF;
    localparam logic [31:0] DenyDataDefault = 32'hDEAD_BEEF;

    // Width of the byte-length field carried in vc mem messages.
    function automatic int unsigned mem_len_nbits(input int unsigned data_nbits);
        return $clog2(data_nbits / 8);
    endfunction

endpackage

// File: rtl/plab5_mcore_proc_req_acc_if.sv
// Valid/ready message channel used for the processor, network and deny ports.
interface plab5_mcore_proc_req_acc_if #(
    parameter int unsigned p_msg_nbits = 77
);
    logic                   val;
    logic                   rdy;
    logic [p_msg_nbits-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/plab5_mcore_acc_window_check.sv
// Combinational secure-window comparator: deny an insecure access that lands
// inside the inclusive [p_sec_base, p_sec_bound] window.
module plab5_mcore_acc_window_check
    import plab5_mcore_acc_pkg::*;
#(
    parameter int unsigned              p_addr_nbits = 32,
    parameter logic [p_addr_nbits-1:0]  p_sec_base   = SecBaseDefault,
    parameter logic [p_addr_nbits-1:0]  p_sec_bound  = SecBoundDefault
) (
    input  logic [p_addr_nbits-1:0] addr_i,
    input  logic                    sec_level_i,
    output logic                    deny_o
);

    logic in_window;

    assign in_window = (addr_i >= p_sec_base) && (addr_i <= p_sec_bound);
    assign deny_o    = !sec_level_i && in_window;

endmodule

// File: rtl/plab5_mcore_proc_req_acc.sv
// Request-side access controller: forwards permitted requests with their security tag,
// answers denied ones locally. Optional deny-address audit: PLAB5_PROC_REQ_ACC_AUDIT_EN.
module plab5_mcore_proc_req_acc
    import plab5_mcore_acc_pkg::*;
#(
    parameter int unsigned              p_opaque_nbits = 8,
    parameter int unsigned              p_addr_nbits   = 32,
    parameter int unsigned              p_data_nbits   = 32,
    parameter logic [p_addr_nbits-1:0]  p_sec_base     = SecBaseDefault,
    parameter logic [p_addr_nbits-1:0]  p_sec_bound    = SecBoundDefault,
    parameter logic [p_data_nbits-1:0]  p_deny_data    = DenyDataDefault,
    parameter int unsigned              p_cnt_nbits    = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              proc_sec_level,
    plab5_mcore_proc_req_acc_if.slave         proc_req,
    plab5_mcore_proc_req_acc_if.master        net_req,
    output logic                              net_req_sec_level,
    plab5_mcore_proc_req_acc_if.master        deny_resp,
    output logic [p_cnt_nbits-1:0]            deny_cnt,
    output logic                              deny_alarm,
    output logic [p_addr_nbits-1:0]           deny_addr
);

    localparam int unsigned LenW    = mem_len_nbits(p_data_nbits);
    localparam int unsigned AddrLsb = p_data_nbits + LenW;
    localparam int unsigned OpqLsb  = AddrLsb + p_addr_nbits;
    localparam int unsigned TypeLsb = OpqLsb + p_opaque_nbits;
    localparam int unsigned ReqW    = TypeLsb + MemTypeNbits;

    localparam logic [p_cnt_nbits-1:0] CntMax = '1;
    localparam logic [p_cnt_nbits-1:0] CntOne = p_cnt_nbits'(1);

    acc_state_e              state_q;
    logic [ReqW-1:0]         msg_q;
    logic                    sec_q;
    logic                    alarm_q;
    logic [p_cnt_nbits-1:0]  cnt_q;

    logic                    accept;
    logic                    req_deny;
    logic [p_addr_nbits-1:0] req_addr;

    assign req_addr = proc_req.msg[AddrLsb +: p_addr_nbits];

    plab5_mcore_acc_window_check #(
        .p_addr_nbits (p_addr_nbits),
        .p_sec_base   (p_sec_base),
        .p_sec_bound  (p_sec_bound)
    ) u_window_check (
        .addr_i      (req_addr),
        .sec_level_i (proc_sec_level),
        .deny_o      (req_deny)
    );

    // Ready whenever the buffer is empty or is being drained this cycle.
    always_comb begin
        case (state_q)
            StFwd:   proc_req.rdy = net_req.rdy;
            StDeny:  proc_req.rdy = deny_resp.rdy;
            default: proc_req.rdy = 1'b1;
        endcase
    end

    assign accept = proc_req.val && proc_req.rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            msg_q   <= '0;
            sec_q   <= 1'b0;
            alarm_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                msg_q   <= proc_req.msg;
                sec_q   <= proc_sec_level;
                state_q <= req_deny ? StDeny : StFwd;
                if (req_deny) begin
                    alarm_q <= 1'b1;
                    if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
            end else if (state_q != StIdle && proc_req.rdy) begin
                state_q <= StIdle;
            end
        end
    end

    assign net_req.val       = (state_q == StFwd);
    assign net_req.msg       = msg_q;
    assign net_req_sec_level = sec_q;

    logic [MemTypeNbits-1:0]   held_type;
    logic [p_opaque_nbits-1:0] held_opq;
    logic [p_data_nbits-1:0]   deny_data;

    assign held_type = msg_q[TypeLsb +: MemTypeNbits];
    assign held_opq  = msg_q[OpqLsb +: p_opaque_nbits];
    assign deny_data = (held_type == MemTypeRead) ? p_deny_data : '0;

    assign deny_resp.val = (state_q == StDeny);
    assign deny_resp.msg = {held_type, held_opq, LenW'(DenyLen), deny_data};

    assign deny_cnt   = cnt_q;
    assign deny_alarm = alarm_q;

`ifdef PLAB5_PROC_REQ_ACC_AUDIT_EN
    logic [p_addr_nbits-1:0] deny_addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deny_addr_q <= '0;
        end else if (accept && req_deny) begin
            deny_addr_q <= req_addr;
        end
    end

    assign deny_addr = deny_addr_q;
`else
    assign deny_addr = '0;
`endif

endmodule

// File: tb/tb_plab5_mcore_proc_req_acc.sv
// Self-checking bench: directed scenarios plus random traffic against a
// single-slot transaction model of the access controller.
`timescale 1ns/1ps
module tb_plab5_mcore_proc_req_acc;

    localparam int ReqW  = 77;
    localparam int RespW = 45;
    localparam logic [31:0] Base     = 32'h0000_8000;
    localparam logic [31:0] Bound    = 32'h0000_FFFF;
    localparam logic [31:0] DenyData = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        proc_sec_level = 1'b0;
    logic        net_req_sec_level;
    logic [7:0]  deny_cnt;
    logic        deny_alarm;
    logic [31:0] deny_addr;

    plab5_mcore_proc_req_acc_if #(.p_msg_nbits(ReqW))  proc_if ();
    plab5_mcore_proc_req_acc_if #(.p_msg_nbits(ReqW))  net_if ();
    plab5_mcore_proc_req_acc_if #(.p_msg_nbits(RespW)) deny_if ();

    plab5_mcore_proc_req_acc dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .proc_sec_level    (proc_sec_level),
        .proc_req          (proc_if),
        .net_req           (net_if),
        .net_req_sec_level (net_req_sec_level),
        .deny_resp         (deny_if),
        .deny_cnt          (deny_cnt),
        .deny_alarm        (deny_alarm),
        .deny_addr         (deny_addr)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: one slot holding nothing (0), a forward (1) or a deny (2).
    int              m_kind;
    logic [ReqW-1:0] m_msg;
    logic            m_sec;
    int              m_cnt;
    bit              m_alarm;
    logic [31:0]     m_daddr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ReqW-1:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                               input logic [31:0] a, input logic [31:0] d);
        return {t, o, a, 2'b00, d};
    endfunction

    function automatic logic [RespW-1:0] exp_deny(input logic [ReqW-1:0] m);
        logic [2:0] t;
        logic [7:0] o;
        t = m[76:74];
        o = m[73:66];
        return {t, o, 2'b00, (t == 3'd0) ? DenyData : 32'h0};
    endfunction

    function automatic void model_reset();
        m_kind  = 0;
        m_msg   = '0;
        m_sec   = 1'b0;
        m_cnt   = 0;
        m_alarm = 1'b0;
        m_daddr = '0;
    endfunction

    function automatic void model_accept(input bit lvl, input logic [ReqW-1:0] m);
        logic [31:0] a;
        bit denied;
        a = m[65:34];
        denied = !lvl && (a >= Base) && (a <= Bound);
        m_msg = m;
        m_sec = lvl;
        if (denied) begin
            m_kind  = 2;
            m_alarm = 1'b1;
            if (m_cnt < 255) m_cnt++;
`ifdef PLAB5_PROC_REQ_ACC_AUDIT_EN
            m_daddr = a;
`endif
        end else begin
            m_kind = 1;
        end
    endfunction

    task automatic check_all(input bit rdy_exp);
        chk("proc_req_rdy", proc_if.rdy, rdy_exp);
        chk("net_req_val", net_if.val, m_kind == 1);
        chk("deny_resp_val", deny_if.val, m_kind == 2);
        if (m_kind == 1) begin
            chk("net_req_msg", net_if.msg, m_msg);
            chk("net_req_sec_level", net_req_sec_level, m_sec);
        end
        if (m_kind == 2) chk("deny_resp_msg", deny_if.msg, exp_deny(m_msg));
        chk("deny_cnt", deny_cnt, m_cnt);
        chk("deny_alarm", deny_alarm, m_alarm);
        chk("deny_addr", deny_addr, m_daddr);
    endtask

    // Called at a negedge; apply inputs, check, then advance one clock.
    task automatic step(input bit v, input bit lvl, input logic [ReqW-1:0] m,
                        input bit nr, input bit dr);
        bit rdy_exp;
        bit acc;
        proc_if.val    = v;
        proc_if.msg    = m;
        proc_sec_level = lvl;
        net_if.rdy     = nr;
        deny_if.rdy    = dr;
        #1;
        rdy_exp = (m_kind == 0) || (m_kind == 1 && nr) || (m_kind == 2 && dr);
        check_all(rdy_exp);
        acc = v && rdy_exp;
        @(posedge clk);
        if (acc) model_accept(lvl, m);
        else if (rdy_exp) m_kind = 0;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 32'h0000_7FFC;
            1: return 32'h0000_7FFF;
            2: return 32'h0000_8000;
            3: return 32'h0000_8004;
            4: return 32'h0000_FFFC;
            5: return 32'h0000_FFFF;
            6: return 32'h0001_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [ReqW-1:0] r;

    initial begin
        model_reset();
        proc_if.val = 1'b0;
        proc_if.msg = '0;
        net_if.rdy  = 1'b0;
        deny_if.rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        chk("reset net_req_val", net_if.val, 1'b0);
        chk("reset deny_resp_val", deny_if.val, 1'b0);
        chk("reset net_req_sec_level", net_req_sec_level, 1'b0);
        chk("reset deny_cnt", deny_cnt, 8'd0);
        chk("reset deny_alarm", deny_alarm, 1'b0);
        chk("reset deny_addr", deny_addr, 32'h0);
        idle();

        // Secure read inside the window is forwarded.
        r = mk_req(3'd0, 8'h11, 32'h0000_9000, 32'h0);
        step(1'b1, 1'b1, r, 1'b1, 1'b1);
        chk("sec fwd val", net_if.val, 1'b1);
        chk("sec fwd msg", net_if.msg, r);
        chk("sec fwd level", net_req_sec_level, 1'b1);
        chk("sec fwd cnt", deny_cnt, 8'd0);
        idle();

        // Insecure read at the window base is denied.
        r = mk_req(3'd0, 8'h5A, 32'h0000_8000, 32'h1234_5678);
        step(1'b1, 1'b0, r, 1'b1, 1'b0);
        chk("deny net_val", net_if.val, 1'b0);
        chk("deny val", deny_if.val, 1'b1);
        chk("deny msg", deny_if.msg, 45'h168_DEAD_BEEF);
        chk("deny cnt", deny_cnt, 8'd1);
        chk("deny alarm", deny_alarm, 1'b1);
`ifdef PLAB5_PROC_REQ_ACC_AUDIT_EN
        chk("deny addr", deny_addr, 32'h0000_8000);
`else
        chk("deny addr", deny_addr, 32'h0);
`endif
        idle();

        // Window edges for an insecure processor.
        r = mk_req(3'd1, 8'h01, 32'h0000_7FFC, 32'hCAFE_0001);
        step(1'b1, 1'b0, r, 1'b1, 1'b1);
        chk("below window val", net_if.val, 1'b1);
        chk("below window level", net_req_sec_level, 1'b0);
        step(1'b1, 1'b0, mk_req(3'd0, 8'h02, 32'h0001_0000, 32'h0), 1'b1, 1'b1);
        step(1'b1, 1'b0, mk_req(3'd1, 8'h03, 32'h0000_FFFF, 32'h55), 1'b1, 1'b1);
        chk("bound write deny msg", deny_if.msg, {3'd1, 8'h03, 2'b00, 32'h0});
        idle();

        // Back-to-back permit then deny with both readies high.
        step(1'b1, 1'b1, mk_req(3'd0, 8'h21, 32'h0000_A000, 32'h0), 1'b1, 1'b1);
        step(1'b1, 1'b0, mk_req(3'd0, 8'h22, 32'h0000_A000, 32'h0), 1'b1, 1'b1);
        idle();
        idle();

        // Network stall with a toggling security level.
        step(1'b1, 1'b0, mk_req(3'd1, 8'h31, 32'h0000_1000, 32'h77), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, i[0], mk_req(3'd0, 8'h32, 32'h0000_9000, 32'h0), 1'b0, 1'b1);
        end
        idle();
        idle();

        // Reset in the middle of a held deny.
        step(1'b1, 1'b0, mk_req(3'd0, 8'h41, 32'h0000_C000, 32'h0), 1'b1, 1'b0);
        proc_if.val = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid reset deny_val", deny_if.val, 1'b0);
        chk("mid reset net_val", net_if.val, 1'b0);
        chk("mid reset cnt", deny_cnt, 8'd0);
        chk("mid reset alarm", deny_alarm, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        // Counter saturation.
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b0, mk_req(3'd0, i[7:0], 32'h0000_8000 + 32'(i), 32'h0), 1'b1, 1'b1);
        end
        chk("saturated cnt", deny_cnt, 8'd255);
        idle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r = mk_req(3'($urandom_range(0, 1)), 8'($urandom), pick_addr(), $urandom);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), r,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
